// File: rtl/pio_edge_in_pkg.sv
// Shared register map and constants for the multi-channel edge-capture input PIO.
// No logic or state; imported by pio_in_sync_chan and pio_edge_in_multi.
package pio_edge_in_pkg;
  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_RISE    = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE = 3'd3;
  localparam logic [2:0] ADDR_FALL    = 3'd4;
  localparam logic [2:0] ADDR_STATUS  = 3'd5;

  localparam int SYNC_STAGES_MIN = 2;
endpackage

// File: rtl/pio_in_sync_chan.sv
// One input channel: SYNC_STAGES-flop synchroniser, optional debounce (PIO_EDGE_IN_DEBOUNCE_EN), prev register.
// Latency SYNC_STAGES cycles to s (+DEBOUNCE_CYCLES when debounced); no backpressure.
module pio_in_sync_chan
  import pio_edge_in_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic s,
  output logic prev
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("pio_in_sync_chan: SYNC_STAGES must be >= %0d and DEBOUNCE_CYCLES >= 1", SYNC_STAGES_MIN);
  end

  logic [SYNC_STAGES-1:0] sync;
  logic                   raw;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], din};
  end

  assign raw = sync[SYNC_STAGES-1];

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          filt;

  // filt follows raw only after DEBOUNCE_CYCLES consecutive cycles of disagreement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (raw == filt) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      filt <= raw;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign s = filt;
`else
  assign s = raw;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= s;
  end

endmodule

// File: rtl/pio_edge_in_multi.sv
// Avalon-MM input PIO with per-channel rise/fall edge capture (W1C), IRQ mask and registered irq; optional debounce via PIO_EDGE_IN_DEBOUNCE_EN.
// Capture sets SYNC_STAGES+1 cycles after a pin change (+DEBOUNCE_CYCLES), irq one cycle later; reads 1 cycle, no wait states.
module pio_edge_in_multi
  import pio_edge_in_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               SYNC_STAGES     = 2,
  parameter logic [WIDTH-1:0] RISE_RESET      = '0,
  parameter logic [WIDTH-1:0] FALL_RESET      = '1,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int DB_LAT = DEBOUNCE_CYCLES;
`else
  localparam int DB_LAT = 0;
`endif
  localparam int ARM_TARGET = SYNC_STAGES + DB_LAT + 1;
  localparam int AW = $clog2(ARM_TARGET + 1);

  logic [WIDTH-1:0] s_vec, prev_vec, ev, w1c, wdat;
  logic [WIDTH-1:0] rise_en, fall_en, mask, capture;
  logic [AW-1:0]    arm_cnt;
  logic             armed, wr;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_in_sync_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[i]),
      .s    (s_vec[i]),
      .prev (prev_vec[i])
    );
  end

  assign wr           = chipselect && !write_n;
  assign wdat         = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;
  assign w1c          = (wr && address == ADDR_CAPTURE) ? wdat : '0;

  // Edges are suppressed until the pipeline has flushed the reset-time zeros
  assign armed = (arm_cnt == AW'(ARM_TARGET));
  assign ev    = armed ? ((s_vec & ~prev_vec & rise_en) | (~s_vec & prev_vec & fall_en)) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm_cnt <= '0;
      rise_en <= RISE_RESET;
      fall_en <= FALL_RESET;
      mask    <= '0;
      capture <= '0;
      irq     <= 1'b0;
      readdata <= '0;
    end else begin
      if (!armed) arm_cnt <= arm_cnt + AW'(1);
      if (wr && address == ADDR_RISE) rise_en <= wdat;
      if (wr && address == ADDR_FALL) fall_en <= wdat;
      if (wr && address == ADDR_MASK) mask    <= wdat;
      capture  <= ev | (capture & ~w1c);
      irq      <= |(capture & mask);
      readdata <= rd_mux;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = s_vec;
      ADDR_RISE:    rd_mux[WIDTH-1:0] = rise_en;
      ADDR_MASK:    rd_mux[WIDTH-1:0] = mask;
      ADDR_CAPTURE: rd_mux[WIDTH-1:0] = capture;
      ADDR_FALL:    rd_mux[WIDTH-1:0] = fall_en;
      ADDR_STATUS:  rd_mux[WIDTH-1:0] = capture & mask;
      default:      rd_mux = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_edge_in_multi.sv
// Self-checking bench for pio_edge_in_multi: register table plus edge/IRQ timing sequences.
module tb_pio_edge_in_multi;
  localparam int W  = 4;
  localparam int SS = 2;
  localparam int DB = 16;
`ifdef PIO_EDGE_IN_DEBOUNCE_EN
  localparam int DBL = DB;
`else
  localparam int DBL = 0;
`endif
  localparam int LAT = SS + 1 + DBL;  // clock edges from pin change to capture update
  localparam int ARM = SS + DBL + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   address = '0;
  logic         chipselect = 1'b0;
  logic         write_n = 1'b1;
  logic [31:0]  writedata = '0;
  logic [W-1:0] in_port = 4'hF;
  logic [31:0]  readdata;
  logic         irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          do_wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[11];

  pio_edge_in_multi #(
    .WIDTH(W), .SYNC_STAGES(SS), .RISE_RESET(4'h0), .FALL_RESET(4'hF), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    exp_t x;
    @(negedge clk);
    address = a;
    sb.push_back('{name: n, exp: e});
    @(negedge clk);
    x = sb.pop_front();
    chk(x.name, readdata, x.exp);
  endtask

  task automatic do_reset(input logic [W-1:0] v);
    @(negedge clk);
    reset = 1'b1; in_port = v; chipselect = 1'b0; write_n = 1'b1; writedata = '0; address = 3'd3;
    #1;
    chk("reset_irq", 32'(irq), 32'h0);
    chk("reset_rd", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (ARM + 2) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{1, 3'd1, 32'h0000_0005, 3'd1, 32'h5, "rise_rw"};
    tbl[1]  = '{1, 3'd1, 32'hFFFF_FFFA, 3'd1, 32'hA, "rise_upper_ignored"};
    tbl[2]  = '{1, 3'd2, 32'h0000_0003, 3'd2, 32'h3, "mask_rw"};
    tbl[3]  = '{1, 3'd4, 32'h0000_0006, 3'd4, 32'h6, "fall_rw"};
    tbl[4]  = '{1, 3'd0, 32'h0000_000F, 3'd0, 32'h0, "data_ro"};
    tbl[5]  = '{1, 3'd5, 32'h0000_000F, 3'd5, 32'h0, "status_ro"};
    tbl[6]  = '{1, 3'd6, 32'h0000_000F, 3'd6, 32'h0, "addr6_zero"};
    tbl[7]  = '{1, 3'd7, 32'h0000_000F, 3'd7, 32'h0, "addr7_zero"};
    tbl[8]  = '{1, 3'd3, 32'h0000_000F, 3'd3, 32'h0, "capture_empty_w1c"};
    tbl[9]  = '{0, 3'd0, 32'h0,         3'd2, 32'h3, "mask_kept"};
    tbl[10] = '{0, 3'd0, 32'h0,         3'd4, 32'h6, "fall_kept"};

    // Reset release with all inputs high: no spurious capture or irq
    @(negedge clk);
    chk("por_rd", readdata, 32'h0);
    chk("por_irq", 32'(irq), 32'h0);
    address = 3'd3;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("arm_irq", 32'(irq), 32'h0);
      chk("arm_capture", readdata, 32'h0);
    end
    rd(3'd0, 32'hF, "data_read");
    rd(3'd1, 32'h0, "rise_reset");
    rd(3'd4, 32'hF, "fall_reset");
    rd(3'd2, 32'h0, "mask_reset");

    // Register access table
    do_reset(4'h0);
    foreach (tbl[i]) begin
      if (tbl[i].do_wr) wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].raddr, tbl[i].exp, tbl[i].name);
    end

    // Falling edge on bit 0 with default enables, exact latency
    do_reset(4'hF);
    wr(3'd2, 32'h1);
    @(negedge clk);
    address = 3'd3; in_port = 4'hE;
    repeat (LAT) @(negedge clk);
    chk("fall0_early_cap", readdata, 32'h0);
    chk("fall0_early_irq", 32'(irq), 32'h0);
    @(negedge clk);
    chk("fall0_cap", readdata, 32'h1);
    chk("fall0_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h1);
    @(negedge clk);
    chk("w1c_cap", readdata, 32'h0);
    chk("w1c_irq", 32'(irq), 32'h0);

    // Rise-only on bit 2
    do_reset(4'h0);
    wr(3'd1, 32'h4);
    wr(3'd4, 32'h0);
    @(negedge clk);
    address = 3'd3; in_port = 4'h4;
    repeat (LAT + 1) @(negedge clk);
    chk("rise2_cap", readdata, 32'h4);
    in_port = 4'h0;
    repeat (LAT + 3) @(negedge clk);
    chk("rise2_no_fall", readdata, 32'h4);
    wr(3'd1, 32'h0);
    rd(3'd3, 32'h4, "enable_change_keeps_cap");

    // W1C on the same cycle as a new edge: set wins
    do_reset(4'h0);
    wr(3'd1, 32'h2);
    @(negedge clk);
    address = 3'd3; in_port = 4'h2;
    repeat (LAT - 1) @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    @(negedge clk);
    chk("set_beats_w1c", readdata, 32'h2);
    wr(3'd3, 32'h2);
    @(negedge clk);
    chk("later_w1c", readdata, 32'h0);

    // Masked capture, then unmask / mask / mid-operation reset
    do_reset(4'h8);
    @(negedge clk);
    address = 3'd3; in_port = 4'h0;
    repeat (LAT + 1) @(negedge clk);
    chk("masked_cap", readdata, 32'h8);
    chk("masked_irq", 32'(irq), 32'h0);
    wr(3'd2, 32'h8);
    chk("unmask_irq_d0", 32'(irq), 32'h0);
    @(negedge clk);
    chk("unmask_irq_d1", 32'(irq), 32'h1);
    rd(3'd5, 32'h8, "status");
    wr(3'd2, 32'h0);
    chk("mask_irq_d0", 32'(irq), 32'h1);
    @(negedge clk);
    chk("mask_irq_d1", 32'(irq), 32'h0);
    wr(3'd2, 32'h8);
    @(negedge clk);
    chk("remask_irq", 32'(irq), 32'h1);
    reset = 1'b1;
    #1;
    chk("midreset_irq", 32'(irq), 32'h0);
    chk("midreset_rd", readdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    rd(3'd3, 32'h0, "midreset_cap");
    rd(3'd2, 32'h0, "midreset_mask");

`ifdef PIO_EDGE_IN_DEBOUNCE_EN
    // Debounce: short glitch ignored, long pulse captured
    do_reset(4'h1);
    @(negedge clk);
    address = 3'd3; in_port = 4'h0;
    repeat (10) @(negedge clk);
    in_port = 4'h1;
    repeat (40) @(negedge clk);
    chk("db_glitch", readdata, 32'h0);
    in_port = 4'h0;
    repeat (20) @(negedge clk);
    in_port = 4'h1;
    repeat (40) @(negedge clk);
    chk("db_pulse", readdata, 32'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_edge_in_multi.md
Name: pio_edge_in_multi

Overview:
- Parametrised Avalon-MM input PIO: WIDTH input channels, each with a multi-stage synchroniser and a previous-value register.
- Per-channel run-time rising/falling edge select, per-channel edge-capture bits (write-1-to-clear), per-channel IRQ mask and a registered IRQ output.
- Next-generation replacement for the single-bit key PIOs in the Nios system; sits on the system interconnect as a slave and feeds one CPU IRQ line.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- RISE_RESET, 0, reset value of the rise-enable register (WIDTH bits).
- FALL_RESET, all ones, reset value of the fall-enable register (WIDTH bits).
- DEBOUNCE_CYCLES, 16, stable-cycle count used only when DEBOUNCE_EN is defined (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  asynchronous external inputs.
- readdata  out  32  registered read data, zero-extended.
- irq  out  1  registered interrupt request.

Behaviour:
- Reset: readdata=0, irq=0, capture=0, mask=0, rise_en=RISE_RESET, fall_en=FALL_RESET, sync/prev flops=0, arm counter=0.
- Write occurs when chipselect && !write_n; no wait states. Writes use writedata[WIDTH-1:0]; upper bits ignored.
- Register map:
  - 0 DATA (RO, synchronised value).
  - 1 RISE_EN (RW).
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAPTURE (R, W1C per bit).
  - 4 FALL_EN (RW).
  - 5 IRQ_STATUS (RO, capture & mask).
  - 6, 7 read 0.
- Writes to RO or unused addresses are ignored.
- readdata is updated every cycle from address, independent of chipselect; read latency is 1 cycle.
- Synchroniser: s = last stage of the SYNC_STAGES chain; prev <= s every cycle.
- Edge detection per bit: rise = s & ~prev & rise_en; fall = ~s & prev & fall_en; ev = rise | fall.
- Arm counter:
  - Counts from 0 to SYNC_STAGES+1 after reset, then holds.
  - ev is forced to 0 until the counter is saturated, so inputs high at reset release raise no spurious edge.
- Capture: capture[i] <= ev[i] ? 1 : (w1c[i] ? 0 : capture[i]). Set wins over a simultaneous write-1-to-clear, so no event is lost.
- Latency: a pin transition stable from cycle 0 sets capture at the end of cycle SYNC_STAGES+1; irq rises one cycle later.
- irq <= |(capture & mask), registered.
- Mask write: a mask write of 0 drops irq one cycle later; unmasking a pending capture raises irq one cycle after the write.
- Changing RISE_EN/FALL_EN affects detection from the next cycle and never alters existing capture bits.
- Reset asserted mid-operation returns everything to reset values immediately, including re-arming the counter.

Optional Feature:
- Macro: PIO_EDGE_IN_DEBOUNCE_EN.
- Defined:
  - Each channel gets a debounce stage after the synchroniser, with a counter of width clog2(DEBOUNCE_CYCLES+1).
  - The filtered value s updates only after the raw synchronised input has differed from s for DEBOUNCE_CYCLES consecutive cycles; any return to s resets the counter.
  - Latency grows by DEBOUNCE_CYCLES.
  - The arm counter target becomes SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Undefined: no debounce logic; s is the synchroniser output directly.

Decomposition:
- Shared package pio_edge_in_pkg holds:
  - Register address localparams: ADDR_DATA=0, ADDR_RISE=1, ADDR_MASK=2, ADDR_CAPTURE=3, ADDR_FALL=4, ADDR_STATUS=5.
  - The SYNC_STAGES minimum constant.
- One sub-module, pio_in_sync_chan:
  - Contains one channel's synchroniser, the optional debounce, and the prev register.
  - Outputs s and prev.
  - Instantiated WIDTH times via generate.

Test Plan:
- Reset release with in_port=4'hF held -> capture stays 0, irq stays 0 for 20 cycles; DATA read returns 0x0000000F.
- Defaults, mask=0x1, in_port[0] 1->0 -> capture=0x1 at SYNC_STAGES+1 cycles after the transition, irq=1 one cycle later; write 0x1 to addr 3 -> capture=0, irq=0 next cycle.
- RISE_EN=0x4, FALL_EN=0, in_port[2] 0->1 then 1->0 -> capture=0x4 only after the rise; no change on the fall.
- W1C of bit 1 on the same cycle an edge on bit 1 is detected -> capture[1] stays 1; a W1C of 0x2 on a later cycle clears it.
- Mask=0, edge on bit 3 -> capture=0x8, irq=0; write mask=0x8 -> irq=1 one cycle later; STATUS reads 0x8.
- With PIO_EDGE_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=16: 10-cycle glitch on bit 0 -> no capture; a 20-cycle low pulse -> capture[0]=1.
